// File: rtl/dmac_request_splitter.sv
// ---------------------------------------------------------------------------
// dmac_request_splitter
//
// Accepts one DMA transfer request (start address + byte length - 1), forwards
// a single request to the downstream address generator, then counts the
// address bursts that generator reports via burst_ack.  eot flags the final
// burst of the transfer; done pulses when that final burst is acknowledged.
//
// Handshakes: a transfer moves on a channel on every rising clk edge where
// valid and ready are both 1.  A source holds valid and its payload stable
// until that edge; a sink may change ready at any time.
//
// Ports
//   clk, resetn                  clock, synchronous active-low reset
//   s_req_valid/ready            upstream transfer request handshake
//   s_req_address                start address in beat units
//   s_req_length                 transfer bytes - 1 (low beat bits ignored)
//   m_req_valid/ready            downstream request handshake
//   m_req_address                start address forwarded downstream
//   m_req_last_burst_length      beats - 1 of the final burst
//   burst_ack                    one pulse per burst accepted downstream
//   eot                          current burst is the last of the transfer
//   abort                        synchronous cancel, highest priority
//   busy, done, error            status; done/error are one-cycle pulses
//   dbg_state_o                  FSM state (0 idle, 1 issue, 2 active)
//   dbg_burst_count_o            bursts remaining minus 1
// ---------------------------------------------------------------------------
module dmac_request_splitter #(
    parameter int C_ADDR_ALIGN_BITS  = 3,
    parameter int C_BURST_ALIGN_BITS = 7,
    parameter int C_DMA_LENGTH_WIDTH = 24
) (
    input  logic                                           clk,
    input  logic                                           resetn,
    input  logic                                           s_req_valid,
    output logic                                           s_req_ready,
    input  logic [31:C_ADDR_ALIGN_BITS]                    s_req_address,
    input  logic [C_DMA_LENGTH_WIDTH-1:0]                  s_req_length,
    output logic                                           m_req_valid,
    input  logic                                           m_req_ready,
    output logic [31:C_ADDR_ALIGN_BITS]                    m_req_address,
    output logic [3:0]                                     m_req_last_burst_length,
    input  logic                                           burst_ack,
    output logic                                           eot,
    input  logic                                           abort,
    output logic                                           busy,
    output logic                                           done,
    output logic                                           error,
    output logic [1:0]                                     dbg_state_o,
    output logic [C_DMA_LENGTH_WIDTH-C_BURST_ALIGN_BITS-1:0] dbg_burst_count_o
);

    localparam int BL = C_BURST_ALIGN_BITS - C_ADDR_ALIGN_BITS;
    localparam int CW = C_DMA_LENGTH_WIDTH - C_BURST_ALIGN_BITS;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [31:C_ADDR_ALIGN_BITS] addr_q, addr_d;
    logic [BL-1:0]              last_q, last_d;
    logic [CW-1:0]              count_q, count_d;
    logic                       m_req_valid_q;
    logic                       done_q, done_d;
    logic                       error_q, error_d;

    // A start address that is not burst aligned cannot be split on burst
    // boundaries by slicing alone, so such requests are rejected.
    logic misaligned;
    assign misaligned = (s_req_address[C_BURST_ALIGN_BITS-1:C_ADDR_ALIGN_BITS] != '0);

    // Sub-beat length bits carry no information for a beat-based splitter.
    logic unused_len_bits;
    assign unused_len_bits = ^s_req_length[C_ADDR_ALIGN_BITS-1:0];

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            last_q        <= '0;
            count_q       <= '0;
            m_req_valid_q <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            last_q        <= last_d;
            count_q       <= count_d;
            // Registered copy of "next state is ISSUE" so m_req_valid is a
            // flop output that tracks the ISSUE state exactly.
            m_req_valid_q <= (state_d == ST_ISSUE);
            done_q        <= done_d;
            error_q       <= error_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        last_d  = last_q;
        count_d = count_q;
        done_d  = 1'b0;
        error_d = 1'b0;

        if (abort) begin
            // Abort wins over any handshake or burst_ack in the same cycle.
            state_d = ST_IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (s_req_valid) begin
                        if (misaligned) begin
                            error_d = 1'b1;
                        end else begin
                            addr_d  = s_req_address;
                            last_d  = s_req_length[C_BURST_ALIGN_BITS-1:C_ADDR_ALIGN_BITS];
                            count_d = s_req_length[C_DMA_LENGTH_WIDTH-1:C_BURST_ALIGN_BITS];
                            state_d = ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (m_req_ready) begin
                        state_d = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (burst_ack) begin
                        if (count_q == '0) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            count_d = count_q - CW'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        s_req_ready             = (state_q == ST_IDLE);
        busy                    = (state_q != ST_IDLE);
        eot                     = (state_q == ST_ACTIVE) && (count_q == '0);
        m_req_valid             = m_req_valid_q;
        m_req_address           = addr_q;
        m_req_last_burst_length = 4'(last_q);
        done                    = done_q;
        error                   = error_q;
        dbg_state_o             = state_q;
        dbg_burst_count_o       = count_q;
    end

endmodule

// File: tb/tb_dmac_request_splitter.sv
// ---------------------------------------------------------------------------
// Testbench for dmac_request_splitter (default parameters: 8-byte beats,
// 128-byte bursts, 24-bit length).  The reference model works in bytes:
// a transfer of length L (bytes - 1) needs L/128 + 1 bursts and its final
// burst carries (L/8) % 16 beats - 1.
// ---------------------------------------------------------------------------
module tb_dmac_request_splitter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        s_req_valid = 1'b0;
    logic        s_req_ready;
    logic [31:3] s_req_address = '0;
    logic [23:0] s_req_length = '0;
    logic        m_req_valid;
    logic        m_req_ready = 1'b0;
    logic [31:3] m_req_address;
    logic [3:0]  m_req_last_burst_length;
    logic        burst_ack = 1'b0;
    logic        eot;
    logic        abort = 1'b0;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  dbg_state;
    logic [16:0] dbg_burst_count;

    int errors = 0;
    int checks = 0;
    logic [32:0] exp_q[$];   // {address, last_burst_length} per issued request

    dmac_request_splitter dut (
        .clk                     (clk),
        .resetn                  (resetn),
        .s_req_valid             (s_req_valid),
        .s_req_ready             (s_req_ready),
        .s_req_address           (s_req_address),
        .s_req_length            (s_req_length),
        .m_req_valid             (m_req_valid),
        .m_req_ready             (m_req_ready),
        .m_req_address           (m_req_address),
        .m_req_last_burst_length (m_req_last_burst_length),
        .burst_ack               (burst_ack),
        .eot                     (eot),
        .abort                   (abort),
        .busy                    (busy),
        .done                    (done),
        .error                   (error),
        .dbg_state_o             (dbg_state),
        .dbg_burst_count_o       (dbg_burst_count)
    );

    // ------------------------------------------------------ clock and reset
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------- drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int bursts_of(input logic [23:0] l);
        return (int'(l) / 128) + 1;
    endfunction

    function automatic logic [3:0] last_of(input logic [23:0] l);
        return 4'((int'(l) / 8) % 16);
    endfunction

    // Handshake an aligned request and check the DUT is now issuing it.
    task automatic start_req(input logic [28:0] a, input logic [23:0] l);
        checks++; if (s_req_ready !== 1'b1) begin errors++; $display("FAIL start_ready: got %b want 1", s_req_ready); end
        s_req_address = a;
        s_req_length  = l;
        s_req_valid   = 1'b1;
        exp_q.push_back({a, last_of(l)});
        tick();
        s_req_valid = 1'b0;
        checks++; if (m_req_valid !== 1'b1) begin errors++; $display("FAIL issue_valid: got %b want 1", m_req_valid); end
        checks++; if (s_req_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL issue_status: ready=%b busy=%b want 0/1", s_req_ready, busy); end
        checks++; if (eot !== 1'b0) begin errors++; $display("FAIL issue_eot: got %b want 0", eot); end
    endtask

    // Hold m_req_ready low for bp cycles (with stray burst_acks), then accept.
    task automatic issue_accept(input int bp);
        logic [32:0] e;
        e = '0;
        checks++;
        if (exp_q.size() == 0) begin
            errors++; $display("FAIL scoreboard_empty: got 0 entries want 1");
        end else begin
            e = exp_q.pop_front();
            if ({m_req_address, m_req_last_burst_length} !== e) begin
                errors++; $display("FAIL issue_payload: got %h/%h want %h/%h", m_req_address, m_req_last_burst_length, e[32:4], e[3:0]);
            end
        end
        for (int k = 0; k < bp; k++) begin
            m_req_ready = 1'b0;
            burst_ack   = 1'($urandom_range(0, 1));
            tick();
            checks++; if (m_req_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b want 1 (cycle %0d)", m_req_valid, k); end
            checks++; if ({m_req_address, m_req_last_burst_length} !== e) begin errors++; $display("FAIL bp_stable: got %h/%h want %h/%h", m_req_address, m_req_last_burst_length, e[32:4], e[3:0]); end
        end
        burst_ack   = 1'b0;
        m_req_ready = 1'b1;
        tick();
        m_req_ready = 1'b0;
        checks++; if (m_req_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL active_entry: valid=%b busy=%b want 0/1", m_req_valid, busy); end
    endtask

    // Acknowledge nb bursts with random gaps; eot must rise only for the last.
    task automatic drain(input int nb, input int max_gap);
        for (int r = nb; r > 0; r--) begin
            int gap;
            gap = $urandom_range(0, max_gap);
            checks++; if (eot !== (r == 1) || done !== 1'b0) begin errors++; $display("FAIL drain_eot: eot=%b done=%b want %b/0 (remaining %0d)", eot, done, (r == 1), r); end
            for (int g = 0; g < gap; g++) begin
                tick();
                checks++; if (eot !== (r == 1) || busy !== 1'b1) begin errors++; $display("FAIL gap_hold: eot=%b busy=%b want %b/1", eot, busy, (r == 1)); end
            end
            burst_ack = 1'b1;
            tick();
            burst_ack = 1'b0;
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_pulse: got %b want 1", done); end
        checks++; if (busy !== 1'b0 || s_req_ready !== 1'b1 || eot !== 1'b0) begin errors++; $display("FAIL done_idle: busy=%b ready=%b eot=%b want 0/1/0", busy, s_req_ready, eot); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_once: got %b want 0", done); end
    endtask

    task automatic misaligned_req(input logic [28:0] a);
        s_req_address = a;
        s_req_length  = 24'($urandom);
        s_req_valid   = 1'b1;
        checks++; if (s_req_ready !== 1'b1) begin errors++; $display("FAIL mis_ready: got %b want 1", s_req_ready); end
        tick();
        s_req_valid = 1'b0;
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL mis_error: got %b want 1", error); end
        checks++; if (m_req_valid !== 1'b0 || s_req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL mis_idle: valid=%b ready=%b busy=%b want 0/1/0", m_req_valid, s_req_ready, busy); end
        tick();
        checks++; if (error !== 1'b0 || m_req_valid !== 1'b0) begin errors++; $display("FAIL mis_once: error=%b valid=%b want 0/0", error, m_req_valid); end
    endtask

    // ----------------------------------------------------------- scenarios
    task automatic test_reset();
        resetn = 1'b0;
        tick();
        tick();
        checks++; if (s_req_ready !== 1'b1 || m_req_valid !== 1'b0) begin errors++; $display("FAIL reset_hs: ready=%b valid=%b want 1/0", s_req_ready, m_req_valid); end
        checks++; if (m_req_address !== '0 || m_req_last_burst_length !== 4'h0) begin errors++; $display("FAIL reset_payload: got %h/%h want 0/0", m_req_address, m_req_last_burst_length); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || eot !== 1'b0) begin errors++; $display("FAIL reset_status: busy=%b done=%b error=%b eot=%b want 0", busy, done, error, eot); end
        checks++; if (dbg_state !== 2'd0 || dbg_burst_count !== 17'h0) begin errors++; $display("FAIL reset_fsm: state=%0d count=%h want 0/0", dbg_state, dbg_burst_count); end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_multi_burst();
        start_req(29'h200, 24'h17F);
        checks++; if (m_req_address !== 29'h200 || m_req_last_burst_length !== 4'hF) begin errors++; $display("FAIL multi_payload: got %h/%h want 200/f", m_req_address, m_req_last_burst_length); end
        issue_accept(0);
        drain(3, 0);
    endtask

    task automatic test_short_burst();
        start_req(29'h400, 24'h47);
        checks++; if (m_req_last_burst_length !== 4'h8) begin errors++; $display("FAIL short_last: got %h want 8", m_req_last_burst_length); end
        issue_accept(0);
        checks++; if (eot !== 1'b1) begin errors++; $display("FAIL short_eot: got %b want 1", eot); end
        drain(1, 2);
    endtask

    task automatic test_misaligned();
        misaligned_req(29'h208);
        repeat (3) begin
            tick();
            checks++; if (m_req_valid !== 1'b0 || s_req_ready !== 1'b1) begin errors++; $display("FAIL mis_quiet: valid=%b ready=%b want 0/1", m_req_valid, s_req_ready); end
        end
    endtask

    task automatic test_backpressure();
        start_req(29'h1230, 24'h1FF);
        issue_accept(5);
        drain(4, 1);
    endtask

    task automatic test_abort();
        // Abort coincident with burst_ack while one burst still remains.
        start_req(29'h300, 24'h0FF);
        issue_accept(0);
        checks++; if (dbg_burst_count !== 17'h1 || eot !== 1'b0) begin errors++; $display("FAIL abort_pre: count=%h eot=%b want 1/0", dbg_burst_count, eot); end
        abort = 1'b1;
        burst_ack = 1'b1;
        tick();
        abort = 1'b0;
        burst_ack = 1'b0;
        checks++; if (dbg_state !== 2'd0 || dbg_burst_count !== 17'h0) begin errors++; $display("FAIL abort_active: state=%0d count=%h want 0/0", dbg_state, dbg_burst_count); end
        checks++; if (done !== 1'b0 || busy !== 1'b0 || s_req_ready !== 1'b1) begin errors++; $display("FAIL abort_status: done=%b busy=%b ready=%b want 0/0/1", done, busy, s_req_ready); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_nodone: got %b want 0", done); end
        // Abort while issuing, even with the downstream ready.
        start_req(29'h10, 24'h7F);
        abort = 1'b1;
        m_req_ready = 1'b1;
        tick();
        abort = 1'b0;
        m_req_ready = 1'b0;
        void'(exp_q.pop_front());
        checks++; if (m_req_valid !== 1'b0 || dbg_state !== 2'd0) begin errors++; $display("FAIL abort_issue: valid=%b state=%0d want 0/0", m_req_valid, dbg_state); end
        // Abort coincident with an upstream handshake discards the request.
        s_req_address = 29'h500;
        s_req_length  = 24'h3FF;
        s_req_valid   = 1'b1;
        abort         = 1'b1;
        tick();
        s_req_valid = 1'b0;
        abort       = 1'b0;
        checks++; if (m_req_valid !== 1'b0 || busy !== 1'b0 || error !== 1'b0 || dbg_burst_count !== 17'h0) begin errors++; $display("FAIL abort_idle: valid=%b busy=%b error=%b count=%h want 0", m_req_valid, busy, error, dbg_burst_count); end
        tick();
        checks++; if (m_req_valid !== 1'b0 || s_req_ready !== 1'b1) begin errors++; $display("FAIL abort_idle_hold: valid=%b ready=%b want 0/1", m_req_valid, s_req_ready); end
    endtask

    task automatic test_reset_mid();
        start_req(29'h40, 24'h2FF);
        issue_accept(0);
        burst_ack = 1'b1;
        tick();
        burst_ack = 1'b0;
        resetn = 1'b0;
        tick();
        checks++; if (s_req_ready !== 1'b1 || m_req_valid !== 1'b0 || busy !== 1'b0 || eot !== 1'b0) begin errors++; $display("FAIL rstmid_hs: ready=%b valid=%b busy=%b eot=%b want 1/0/0/0", s_req_ready, m_req_valid, busy, eot); end
        checks++; if (m_req_address !== '0 || m_req_last_burst_length !== 4'h0 || dbg_burst_count !== 17'h0) begin errors++; $display("FAIL rstmid_regs: addr=%h last=%h count=%h want 0", m_req_address, m_req_last_burst_length, dbg_burst_count); end
        checks++; if (done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL rstmid_pulse: done=%b error=%b want 0/0", done, error); end
        resetn = 1'b1;
        tick();
        checks++; if (done !== 1'b0 || error !== 1'b0 || dbg_state !== 2'd0) begin errors++; $display("FAIL rstmid_after: done=%b error=%b state=%0d want 0/0/0", done, error, dbg_state); end
    endtask

    task automatic test_max_length();
        start_req(29'h0, 24'hFFFFFF);
        checks++; if (m_req_last_burst_length !== 4'hF) begin errors++; $display("FAIL max_last: got %h want f", m_req_last_burst_length); end
        issue_accept(0);
        checks++; if (dbg_burst_count !== 17'h1FFFF || eot !== 1'b0) begin errors++; $display("FAIL max_load: count=%h eot=%b want 1ffff/0", dbg_burst_count, eot); end
        // 131072 bursts in total; walk the first 64 and then cancel.
        for (int k = 1; k <= 64; k++) begin
            burst_ack = 1'b1;
            tick();
            checks++; if (dbg_burst_count !== 17'(131071 - k) || done !== 1'b0 || eot !== 1'b0) begin errors++; $display("FAIL max_count: count=%h done=%b eot=%b want %h/0/0", dbg_burst_count, done, eot, 17'(131071 - k)); end
        end
        burst_ack = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (dbg_state !== 2'd0 || dbg_burst_count !== 17'h0 || done !== 1'b0) begin errors++; $display("FAIL max_abort: state=%0d count=%h done=%b want 0", dbg_state, dbg_burst_count, done); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            logic [28:0] a;
            logic [23:0] l;
            a = 29'($urandom);
            if ($urandom_range(0, 1) == 1) a = a - 29'(a % 16);
            l = 24'($urandom_range(0, 24'h7FF));
            // Stray burst_ack while idle must be ignored.
            burst_ack = 1'($urandom_range(0, 1));
            tick();
            burst_ack = 1'b0;
            checks++; if (s_req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rand_idle: ready=%b busy=%b done=%b want 1/0/0", s_req_ready, busy, done); end
            if ((a % 16) != 0) begin
                misaligned_req(a);
            end else begin
                start_req(a, l);
                issue_accept($urandom_range(0, 3));
                drain(bursts_of(l), 2);
            end
        end
    endtask

    // ------------------------------------------------------------ sequence
    initial begin
        test_reset();
        test_multi_burst();
        test_short_burst();
        test_misaligned();
        test_backpressure();
        test_abort();
        test_reset_mid();
        test_max_length();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
